// File: rtl/vga_tta_core.sv
// rtl/vga_tta_core.sv - move-only TTA core between the host byte/instruction port and VGA memory
module vga_tta_core (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        gate_ni,
    input  logic        i_read_i,
    input  logic        i_write_i,
    output logic        i_ready_o,
    input  logic [8:0]  i_addr_i,
    input  logic [35:0] i_data_i,
    output logic [35:0] i_data_o,
    input  logic        p_pres_i,
    input  logic [7:0]  p_data_i,
    output logic        p_ack_o,
    output logic        p_send_o,
    output logic [7:0]  p_data_o,
    output logic        v_read_o,
    output logic        v_write_o,
    input  logic        v_ready_i,
    output logic [17:0] v_addr_o,
    input  logic [15:0] v_data_i,
    output logic [15:0] v_data_o
);
    localparam logic [5:0] SRC_IMM    = 6'h10;
    localparam logic [5:0] SRC_PIN    = 6'h11;
    localparam logic [5:0] SRC_VDATA  = 6'h12;
    localparam logic [5:0] SRC_ALUR   = 6'h13;
    localparam logic [5:0] SRC_STATUS = 6'h14;
    localparam logic [5:0] DST_ALUA   = 6'h10;
    localparam logic [5:0] DST_ADD    = 6'h11;
    localparam logic [5:0] DST_SUB    = 6'h12;
    localparam logic [5:0] DST_AND    = 6'h13;
    localparam logic [5:0] DST_OR     = 6'h14;
    localparam logic [5:0] DST_XOR    = 6'h15;
    localparam logic [5:0] DST_POUT   = 6'h20;
    localparam logic [5:0] DST_VLO    = 6'h21;
    localparam logic [5:0] DST_VHI    = 6'h22;
    localparam logic [5:0] DST_VWR    = 6'h23;
    localparam logic [5:0] DST_VRD    = 6'h24;
    localparam logic [5:0] DST_JUMP   = 6'h30;

    logic [35:0] imem [512];
    logic [8:0]  pc;
    logic [30:0] ir;        // only the decoded fields {V, guard, dst, src, imm}
    logic        ir_valid;
    logic [15:0] regs [16];
    logic [15:0] alu_a, alu_r, vdata;
    logic        z_flag, c_flag;
    logic [17:0] vaddr;
    logic [7:0]  in_byte;
    logic        in_valid, overrun;

    logic        ir_v;
    logic [1:0]  ir_guard;
    logic [5:0]  dst, src;
    logic [15:0] imm;
    assign {ir_v, ir_guard, dst, src, imm} = ir;

    logic guard_ok, fire, vid_pending, stall, advance, in_read, status_read, is_alu;
    logic [15:0] value, alu_new;
    logic [16:0] alu_sum;
    logic        alu_c;

    always_comb begin
        guard_ok = 1'b0;
        case (ir_guard)
            2'b00: guard_ok = 1'b1;
            2'b01: guard_ok = z_flag;
            2'b10: guard_ok = !z_flag;
            2'b11: guard_ok = 1'b0;
        endcase
    end

    assign fire        = ir_valid && ir_v && guard_ok;
    assign vid_pending = v_read_o || v_write_o;
    // An empty input buffer or an outstanding video access holds the move in execute.
    assign stall       = vid_pending || (fire && src == SRC_PIN && !in_valid);
    assign advance     = gate_ni && !stall;
    assign in_read     = advance && fire && src == SRC_PIN;
    assign status_read = advance && fire && src == SRC_STATUS;
    assign is_alu      = (dst >= DST_ADD) && (dst <= DST_XOR);
    assign v_addr_o    = vaddr;

    always_comb begin
        value = '0;
        if (src[5:4] == 2'b00) begin
            value = regs[src[3:0]];
        end else begin
            case (src)
                SRC_IMM:    value = imm;
                SRC_PIN:    value = {8'h00, in_byte};
                SRC_VDATA:  value = vdata;
                SRC_ALUR:   value = alu_r;
                SRC_STATUS: value = {12'h000, overrun, in_valid, c_flag, z_flag};
                default:    value = '0;
            endcase
        end
    end

    assign alu_sum = {1'b0, alu_a} + {1'b0, value};

    always_comb begin
        alu_new = '0;
        alu_c   = 1'b0;
        case (dst)
            DST_ADD: {alu_c, alu_new} = alu_sum;
            DST_SUB: begin
                alu_new = alu_a - value;
                alu_c   = alu_a < value;
            end
            DST_AND: alu_new = alu_a & value;
            DST_OR:  alu_new = alu_a | value;
            DST_XOR: alu_new = alu_a ^ value;
            default: alu_new = '0;
        endcase
    end

    // Contents survive reset; read-first so a same-cycle fetch sees the old word.
    always_ff @(posedge clock_i) begin
        if (i_write_i) imem[i_addr_i] <= i_data_i;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            pc <= '0; ir <= '0; ir_valid <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            alu_a <= '0; alu_r <= '0; vdata <= '0; vaddr <= '0;
            z_flag <= 1'b0; c_flag <= 1'b0;
            in_byte <= '0; in_valid <= 1'b0; overrun <= 1'b0;
            i_ready_o <= 1'b0; i_data_o <= '0;
            p_ack_o <= 1'b0; p_send_o <= 1'b0; p_data_o <= '0;
            v_read_o <= 1'b0; v_write_o <= 1'b0; v_data_o <= '0;
        end else begin
            i_ready_o <= i_read_i;
            if (i_read_i) i_data_o <= imem[i_addr_i];
            p_ack_o  <= p_pres_i;
            p_send_o <= 1'b0;

            if (status_read) overrun <= 1'b0;
            if (p_pres_i) begin
                in_byte  <= p_data_i;
                in_valid <= 1'b1;
                if (in_valid && !in_read) overrun <= 1'b1;
            end else if (in_read) begin
                in_valid <= 1'b0;
            end

            if (vid_pending && gate_ni && v_ready_i) begin
                v_read_o  <= 1'b0;
                v_write_o <= 1'b0;
                if (v_read_o) vdata <= v_data_i;
            end

            if (advance) begin
                ir       <= {imem[pc][35:33], imem[pc][31:20], imem[pc][15:0]};
                ir_valid <= 1'b1;
                pc       <= pc + 9'd1;
                if (fire) begin
                    if (dst[5:4] == 2'b00) regs[dst[3:0]] <= value;
                    if (is_alu) begin
                        alu_r  <= alu_new;
                        z_flag <= (alu_new == 16'h0000);
                        c_flag <= alu_c;
                    end
                    case (dst)
                        DST_ALUA: alu_a <= value;
                        DST_POUT: begin
                            p_send_o <= 1'b1;
                            p_data_o <= value[7:0];
                        end
                        DST_VLO:  vaddr[15:0] <= value;
                        DST_VHI:  vaddr[17:16] <= value[1:0];
                        DST_VWR: begin
                            v_data_o  <= value;
                            v_write_o <= 1'b1;
                        end
                        DST_VRD:  v_read_o <= 1'b1;
                        DST_JUMP: begin
                            pc       <= value[8:0];
                            ir_valid <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_tta_core.sv
// tb/tb_vga_tta_core.sv - directed and randomized checks of vga_tta_core against an ISA-level model
module tb_vga_tta_core;
    logic        clock_i = 1'b0, reset_i = 1'b1, gate_ni = 1'b0;
    logic        i_read_i = 1'b0, i_write_i = 1'b0, p_pres_i = 1'b0, v_ready_i = 1'b0;
    logic [8:0]  i_addr_i = '0;
    logic [35:0] i_data_i = '0;
    logic [7:0]  p_data_i = '0;
    logic [15:0] v_data_i = '0;
    logic        i_ready_o, p_ack_o, p_send_o, v_read_o, v_write_o;
    logic [35:0] i_data_o;
    logic [7:0]  p_data_o;
    logic [17:0] v_addr_o;
    logic [15:0] v_data_o;

    typedef struct { int t; logic [15:0] d; } ev_t;
    ev_t send_q[$];
    ev_t vw_q[$];
    int  ack_q[$];
    int  n_vec = 0, n_err = 0, cyc = 0, t0 = 0;

    vga_tta_core dut (
        .clock_i(clock_i), .reset_i(reset_i), .gate_ni(gate_ni),
        .i_read_i(i_read_i), .i_write_i(i_write_i), .i_ready_o(i_ready_o),
        .i_addr_i(i_addr_i), .i_data_i(i_data_i), .i_data_o(i_data_o),
        .p_pres_i(p_pres_i), .p_data_i(p_data_i), .p_ack_o(p_ack_o),
        .p_send_o(p_send_o), .p_data_o(p_data_o),
        .v_read_o(v_read_o), .v_write_o(v_write_o), .v_ready_i(v_ready_i),
        .v_addr_o(v_addr_o), .v_data_i(v_data_i), .v_data_o(v_data_o)
    );

    always #5 clock_i = ~clock_i;
    always @(posedge clock_i) cyc++;
    always @(negedge clock_i) begin
        if (p_send_o) send_q.push_back('{cyc, {8'h00, p_data_o}});
        if (p_ack_o) ack_q.push_back(cyc);
        if (v_write_o && v_ready_i) vw_q.push_back('{cyc, v_data_o});
    end

    function automatic logic [82:0] outs();
        return {i_ready_o, i_data_o, p_ack_o, p_send_o, p_data_o, v_read_o, v_write_o, v_addr_o, v_data_o};
    endfunction

    function automatic logic [35:0] mv(input logic [1:0] g, input logic [5:0] d, input logic [5:0] s,
                                       input logic [15:0] imm);
        return {1'b1, g, 1'b0, d, s, 4'h0, imm};
    endfunction

    function automatic ev_t sq(input int i);
        ev_t e = '{-1, 16'h0};
        if (i < send_q.size()) e = send_q[i];
        return e;
    endfunction

    function automatic ev_t vq(input int i);
        ev_t e = '{-1, 16'h0};
        if (i < vw_q.size()) e = vw_q[i];
        return e;
    endfunction

    function automatic int aq(input int i);
        return (i < ack_q.size()) ? ack_q[i] : -1;
    endfunction

    // Reference ALU from the instruction-set rules, in plain integer arithmetic.
    function automatic void alu_ref(input int op, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output logic c);
        int s;
        c = 1'b0;
        case (op)
            0: begin s = int'(a) + int'(b); r = 16'(s); c = (s > 65535); end
            1: begin s = int'(a) - int'(b); r = 16'(s); c = (int'(a) < int'(b)); end
            2: r = a & b;
            3: r = a | b;
            default: r = a ^ b;
        endcase
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(posedge clock_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hw(input logic [8:0] a, input logic [35:0] w);
        i_write_i = 1'b1; i_addr_i = a; i_data_i = w;
        step();
        i_write_i = 1'b0;
    endtask

    task automatic boot(input logic g);
        reset_i = 1'b1;
        step(3);
        reset_i = 1'b0;
        gate_ni = g;
        t0 = cyc;
        send_q.delete(); vw_q.delete(); ack_q.delete();
    endtask

    initial begin
        int toggles, tp;
        logic [15:0] a, b, r, d;
        logic [7:0] b1, b2;
        logic c;
        int op, k;

        step(2);
        for (int i = 0; i < 512; i++) hw(9'(i), 36'h0);
        reset_i = 1'b1; gate_ni = 1'b1;
        step(3);
        chk("reset_outputs", outs(), '0);
        reset_i = 1'b0;
        toggles = 0;
        repeat (50) begin
            step();
            if (outs() !== '0) toggles++;
        end
        chk("idle_after_reset", toggles, 0);

        hw(9'd3, 36'h9_0000_00A5);
        i_read_i = 1'b1; i_addr_i = 9'd3;
        step();
        i_read_i = 1'b0;
        chk("host_read_ready", i_ready_o, 1'b1);
        chk("host_read_data", i_data_o, 36'h9_0000_00A5);
        step();
        chk("host_ready_pulse", i_ready_o, 1'b0);

        reset_i = 1'b1;
        hw(9'd0, mv(2'b00, 6'h20, 6'h11, 16'h0));
        hw(9'd1, mv(2'b00, 6'h30, 6'h10, 16'h0));
        boot(1'b1);
        step(10);
        chk("echo_no_early_send", send_q.size(), 0);
        p_pres_i = 1'b1; p_data_i = 8'h5A; tp = cyc;
        step();
        p_pres_i = 1'b0;
        step(4);
        chk("echo_send_count", send_q.size(), 1);
        chk("echo_send_data", sq(0).d, 16'h005A);
        chk("echo_send_time", sq(0).t, tp + 2);
        chk("echo_ack_count", ack_q.size(), 1);
        chk("echo_ack_time", aq(0), tp + 1);

        step(5);
        send_q.delete(); ack_q.delete();
        p_pres_i = 1'b1; p_data_i = 8'hC3; tp = cyc;
        step();
        p_pres_i = 1'b0; gate_ni = 1'b0;
        step();
        gate_ni = 1'b1;
        step(4);
        chk("gate_send_data", sq(0).d, 16'h00C3);
        chk("gate_send_time", sq(0).t, tp + 3);
        chk("gate_ack_time", aq(0), tp + 1);
        chk("gate_send_count", send_q.size(), 1);

        reset_i = 1'b1;
        hw(9'd0,  mv(2'b00, 6'h10, 6'h10, 16'd3));
        hw(9'd1,  mv(2'b00, 6'h11, 6'h10, 16'd5));
        hw(9'd2,  mv(2'b00, 6'h20, 6'h13, 16'h0));
        hw(9'd3,  mv(2'b00, 6'h12, 6'h10, 16'd3));
        hw(9'd4,  mv(2'b10, 6'h20, 6'h10, 16'hEE));
        hw(9'd5,  mv(2'b01, 6'h30, 6'h10, 16'd8));
        hw(9'd6,  mv(2'b00, 6'h20, 6'h10, 16'hDD));
        hw(9'd7,  mv(2'b00, 6'h20, 6'h10, 16'hDD));
        hw(9'd8,  mv(2'b00, 6'h20, 6'h14, 16'h0));
        hw(9'd9,  mv(2'b00, 6'h20, 6'h10, 16'h77));
        hw(9'd10, mv(2'b00, 6'h30, 6'h10, 16'd10));
        boot(1'b1);
        step(20);
        alu_ref(0, 16'd3, 16'd5, r, c);
        chk("alu_add_send", sq(0).d, {8'h00, r[7:0]});
        chk("alu_add_time", sq(0).t, t0 + 4);
        alu_ref(1, 16'd3, 16'd3, r, c);
        chk("guard_status_send", sq(1).d, {12'h000, 2'b00, c, r == 16'h0});
        chk("guard_jump_time", sq(1).t, t0 + 9);
        chk("after_jump_send", sq(2).d, 16'h0077);
        chk("after_jump_time", sq(2).t, t0 + 10);
        chk("guard_send_count", send_q.size(), 3);

        reset_i = 1'b1;
        hw(9'd0, mv(2'b00, 6'h21, 6'h10, 16'h1234));
        hw(9'd1, mv(2'b00, 6'h22, 6'h10, 16'd2));
        hw(9'd2, mv(2'b00, 6'h23, 6'h10, 16'hBEEF));
        hw(9'd3, mv(2'b00, 6'h20, 6'h10, 16'h42));
        hw(9'd4, mv(2'b00, 6'h30, 6'h10, 16'd4));
        v_ready_i = 1'b0;
        boot(1'b1);
        step(4);
        for (int i = 0; i < 5; i++) begin
            chk("vwrite_held", {v_write_o, v_read_o, v_addr_o, v_data_o}, {1'b1, 1'b0, 18'h21234, 16'hBEEF});
            step();
        end
        chk("vwrite_pc_frozen", send_q.size(), 0);
        v_ready_i = 1'b1;
        step();
        v_ready_i = 1'b0;
        chk("vwrite_released", v_write_o, 1'b0);
        step();
        chk("vwrite_next_instr", {p_send_o, p_data_o}, {1'b1, 8'h42});
        chk("vwrite_count", vw_q.size(), 1);

        reset_i = 1'b1;
        hw(9'd0, mv(2'b00, 6'h20, 6'h14, 16'h0));
        hw(9'd1, mv(2'b00, 6'h20, 6'h11, 16'h0));
        hw(9'd2, mv(2'b00, 6'h20, 6'h14, 16'h0));
        hw(9'd3, mv(2'b00, 6'h30, 6'h10, 16'd3));
        boot(1'b0);
        b1 = 8'($urandom); b2 = 8'($urandom);
        p_pres_i = 1'b1; p_data_i = b1;
        step();
        p_data_i = b2;
        step();
        p_pres_i = 1'b0;
        step();
        gate_ni = 1'b1;
        step(10);
        chk("overrun_status", sq(0).d, 16'h000C);
        chk("overrun_last_byte", sq(1).d, {8'h00, b2});
        chk("overrun_cleared", sq(2).d, 16'h0000);
        chk("overrun_ack_count", ack_q.size(), 2);

        v_ready_i = 1'b1;
        for (int trial = 0; trial < 20; trial++) begin
            a  = 16'($urandom);
            b  = (trial % 4 == 0) ? a : 16'($urandom);
            op = $urandom_range(0, 4);
            k  = $urandom_range(0, 15);
            reset_i = 1'b1;
            hw(9'd0, mv(2'b00, 6'(k), 6'h10, a));
            hw(9'd1, mv(2'b00, 6'h10, 6'(k), 16'h0));
            hw(9'd2, mv(2'b00, 6'(6'h11 + op), 6'h10, b));
            hw(9'd3, mv(2'b00, 6'h23, 6'h13, 16'h0));
            hw(9'd4, mv(2'b00, 6'h20, 6'h14, 16'h0));
            hw(9'd5, mv(2'b00, 6'h30, 6'h10, 16'd5));
            boot(1'b1);
            step(14);
            alu_ref(op, a, b, r, c);
            chk("rand_alu_result", {vw_q.size(), vq(0).d}, {32'd1, r});
            chk("rand_alu_status", {send_q.size(), sq(0).d}, {32'd1, 12'h000, 2'b00, c, r == 16'h0});
        end

        for (int trial = 0; trial < 4; trial++) begin
            d = 16'($urandom);
            v_data_i = d;
            reset_i = 1'b1;
            hw(9'd0, mv(2'b00, 6'h24, 6'h10, 16'h0));
            hw(9'd1, mv(2'b00, 6'h23, 6'h12, 16'h0));
            hw(9'd2, mv(2'b00, 6'h30, 6'h10, 16'd2));
            boot(1'b1);
            step(12);
            chk("rand_vread_loop", {vw_q.size(), vq(0).d}, {32'd1, d});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vga_tta_core.md
# vga_tta_core

Module `vga_tta_core`: a small transport-triggered (move-only) processor that sits between the PCI bridge and the VGA memory controller. The host loads a 512×36 instruction memory over the `i_*` port and feeds bytes over the `p_*` port. The core executes one move per cycle, producing bytes back to the host and read/write cycles to video memory on the `v_*` port.

## Interface
- Parameters: none; all widths are fixed as listed below.
- `clock_i` in 1: single clock; everything is rising-edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `gate_ni` in 1: low freezes core execution.
- `i_read_i` in 1: host instruction-memory read strobe.
- `i_write_i` in 1: host instruction-memory write strobe.
- `i_ready_o` out 1: read data valid; 1-cycle pulse.
- `i_addr_i` in 9: instruction-memory address.
- `i_data_i` in 36: write data.
- `i_data_o` out 36: read data.
- `p_pres_i` in 1: host byte present; 1-cycle strobe.
- `p_data_i` in 8: host byte.
- `p_ack_o` out 1: byte accepted.
- `p_send_o` out 1: core byte out; 1-cycle strobe.
- `p_data_o` out 8: core byte.
- `v_read_o` out 1: video read request; held until ready.
- `v_write_o` out 1: video write request; held until ready.
- `v_ready_i` in 1: video access complete.
- `v_addr_o` out 18: video address.
- `v_data_i` in 16: video read data.
- `v_data_o` out 16: video write data.

## Operation
- Instruction format:
  - [35] V: 0 = NOP.
  - [34:33] guard: 00 always, 01 if Z, 10 if !Z, 11 never.
  - [31:26] dst.
  - [25:20] src.
  - [15:0] imm.
  - Other bits are ignored.
- Instruction memory: 512×36, initialised to zero, dual-port, read-first.
- Architectural state:
  - R0–R15 are 16-bit registers.
  - ALU_A and ALU_R are 16-bit.
  - Flags Z and C.
  - VADDR is 18-bit, with LO = [15:0] and HI = [17:16].
  - VDATA is 16-bit.
  - Input buffer: 8-bit byte plus a valid bit.
  - Overrun flag.
- Sources:
  - 0x00–0x0F: Rn.
  - 0x10: imm.
  - 0x11: PORT_IN, the zero-extended byte. Reading it clears valid. If the buffer is empty the core stalls until a byte arrives.
  - 0x12: VDATA.
  - 0x13: ALU_R.
  - 0x14: STATUS = {12'b0, overrun, valid, C, Z}. Reading it clears overrun.
- Destinations:
  - 0x00–0x0F: Rn.
  - 0x10: ALU_A.
  - 0x11–0x15: ADD, SUB, AND, OR, XOR triggers. ALU_R = A op value. Z = (ALU_R == 0). C = carry out on ADD, borrow (A < value) on SUB, 0 on the logic ops.
  - 0x20: PORT_OUT. Drives `p_data_o` = value[7:0] and pulses `p_send_o`.
  - 0x21: VADDR_LO.
  - 0x22: VADDR_HI.
  - 0x23: VWRITE. Drives `v_data_o` = value and `v_write_o` = 1.
  - 0x24: VREAD. Drives `v_read_o` = 1; `v_data_i` is captured into VDATA on ready.
  - 0x30: JUMP. PC = value[8:0].
- Unlisted source codes read 0. Unlisted destination codes discard the value.
- A failed guard or V = 0 means the instruction has no effect.
- `v_addr_o` continuously reflects VADDR.
- Host port:
  - `i_write_i` writes `i_data_i` to `i_addr_i`.
  - `i_read_i` returns the word on `i_data_o` with `i_ready_o` = 1 the next cycle.
  - The host port works regardless of gate or stall.
- Input port:
  - `p_pres_i` high loads `p_data_i`, sets valid, and pulses `p_ack_o` the next cycle.
  - Arrival while valid: the new byte overwrites and overrun is set.
  - Arrival in the same cycle as a core read: the new byte wins and valid stays 1.
- Reset (asynchronous):
  - PC = 0; pipeline squashed.
  - Registers, flags, buffer and overrun = 0.
  - All outputs = 0.
  - Instruction-memory contents are retained.

## Timing
- Two stages:
  - Fetch: PC is presented to the synchronous RAM in cycle n.
  - Execute: the word is executed in cycle n+1.
  - Throughput is one instruction per cycle.
- The first instruction executes in the 2nd cycle after reset deasserts.
- A taken JUMP squashes the sequentially fetched word, giving a 1-cycle bubble.
- Execute results (register, ALU, flag writes) are visible to the next instruction.
- `p_send_o` is high in the cycle after the PORT_OUT move executes.
- VWRITE/VREAD:
  - The request is asserted the cycle after the move.
  - It is held until `v_ready_i` is sampled high, then deasserted.
  - The core stalls while the request is pending.
- `gate_ni` low:
  - PC, pipeline and all core state hold.
  - Pending video requests stay asserted.
  - Input buffer, `p_ack_o` and the host port continue to operate.
  - Execution resumes with no lost or duplicated instruction.
- A host write to the address being fetched in the same cycle: the core sees the old word.
- PC wraps 511 → 0.

## Test plan
1. Assert `reset_i` for 3 cycles → all outputs 0; with a zeroed instruction memory, nothing toggles for 50 cycles afterwards.
2. Write 36'h9_0000_00A5 at address 3, then read address 3 → next cycle `i_ready_o` = 1 and `i_data_o` = 36'h9_0000_00A5.
3. Program `PORT_IN→PORT_OUT; JUMP 0`, then pulse `p_pres_i` with 0x5A → `p_ack_o` next cycle; `p_send_o` with `p_data_o` = 0x5A; no `p_send_o` before the byte arrives.
4. Program `imm3→ALU_A; imm5→ADD; ALU_R→PORT_OUT` → `p_data_o` = 0x08. `imm3→SUB` with A = 3 → Z = 1; a guarded-if-Z JUMP is taken and a guarded-if-!Z PORT_OUT is skipped.
5. `imm0x1234→VADDR_LO; imm2→VADDR_HI; imm0xBEEF→VWRITE` with `v_ready_i` = 0 for 5 cycles → `v_addr_o` = 0x21234, `v_data_o` = 0xBEEF, `v_write_o` held and PC frozen; raise ready → completes and the next instruction executes.
6. Pull `gate_ni` low for 1 cycle during the scenario-3 echo → `p_send_o` is delayed by exactly 1 cycle and `p_ack_o` timing is unchanged.
